// File: rtl/pkt_stream_dispatcher.sv
// Packet stream dispatcher: maps a flow key to a stream ID through a fully-associative
// table. It then emits load_state, the packet bytes and eop with fixed spacing for the DFA wrappers.
module pkt_stream_dispatcher #(
  parameter int NUM_STREAMS = 64,
  parameter int ID_W        = 6,
  parameter int KEY_W       = 32,
  parameter int LOAD_GAP    = 2,
  parameter int EOP_DELAY   = 4,
  parameter bit DEFAULT_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [7:0]       in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [KEY_W-1:0] in_key,
  input  logic             cfg_wr,
  input  logic [ID_W-1:0]  cfg_id,
  input  logic             cfg_en,
  output logic [7:0]       char_in,
  output logic             char_in_vld,
  output logic             load_state,
  output logic             new_stream_id,
  output logic [ID_W-1:0]  stream_id,
  output logic             enable,
  output logic             eop,
  output logic [15:0]      pkt_cnt,
  output logic [15:0]      evict_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_LOAD, S_GAP, S_STREAM, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [KEY_W-1:0]       key_q, key_d;
  logic [7:0]             hold_data_q, hold_data_d;
  logic                   hold_eop_q, hold_eop_d;
  logic [KEY_W-1:0]       key_tab_q [NUM_STREAMS];
  logic [KEY_W-1:0]       key_tab_d [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] vld_tab_q, vld_tab_d;
  logic [NUM_STREAMS-1:0] en_tab_q, en_tab_d;
  logic [ID_W-1:0]        alloc_ptr_q, alloc_ptr_d;

  logic [7:0]             char_in_q, char_in_d;
  logic                   char_in_vld_q, char_in_vld_d;
  logic                   load_state_q, load_state_d;
  logic                   new_stream_id_q, new_stream_id_d;
  logic [ID_W-1:0]        stream_id_q, stream_id_d;
  logic                   enable_q, enable_d;
  logic                   eop_q, eop_d;
  logic [15:0]            pkt_cnt_q, pkt_cnt_d;
  logic [15:0]            evict_cnt_q, evict_cnt_d;

  logic                   hit;
  logic [ID_W-1:0]        hit_idx;
  logic                   gap_done;
  logic                   in_rdy_c;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      if (vld_tab_q[i] && (key_tab_q[i] == key_q)) begin
        hit     = 1'b1;
        hit_idx = ID_W'(i);
      end
    end
  end

  // A beat transfers on a cycle where in_vld && in_rdy are both high. in_rdy depends
  // combinationally on in_vld in IDLE. In IDLE it is held low during the eop cycle so the next sop lands after it.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    key_d           = key_q;
    hold_data_d     = hold_data_q;
    hold_eop_d      = hold_eop_q;
    key_tab_d       = key_tab_q;
    vld_tab_d       = vld_tab_q;
    en_tab_d        = en_tab_q;
    alloc_ptr_d     = alloc_ptr_q;
    char_in_d       = char_in_q;
    char_in_vld_d   = 1'b0;
    load_state_d    = 1'b0;
    new_stream_id_d = new_stream_id_q;
    stream_id_d     = stream_id_q;
    enable_d        = enable_q;
    eop_d           = 1'b0;
    pkt_cnt_d       = pkt_cnt_q;
    evict_cnt_d     = evict_cnt_q;
    in_rdy_c        = 1'b0;
    gap_done        = 1'b0;

    if (cfg_wr) en_tab_d[cfg_id] = cfg_en;

    case (state_q)
      S_IDLE: begin
        in_rdy_c = in_vld && !eop_q;
        if (in_vld && !eop_q && in_sop) begin
          key_d       = in_key;
          hold_data_d = in_data;
          hold_eop_d  = in_eop;
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        load_state_d = 1'b1;
        state_d      = S_LOAD;
        if (hit) begin
          stream_id_d     = hit_idx;
          new_stream_id_d = 1'b0;
          enable_d        = en_tab_q[hit_idx];
        end else begin
          stream_id_d            = alloc_ptr_q;
          new_stream_id_d        = 1'b1;
          enable_d               = DEFAULT_EN;
          key_tab_d[alloc_ptr_q] = key_q;
          vld_tab_d[alloc_ptr_q] = 1'b1;
          en_tab_d[alloc_ptr_q]  = DEFAULT_EN;
          alloc_ptr_d            = alloc_ptr_q + 1'b1;
          if (vld_tab_q[alloc_ptr_q]) evict_cnt_d = evict_cnt_q + 16'd1;
        end
      end
      S_LOAD: begin
        cnt_d = '0;
        if (LOAD_GAP == 0) gap_done = 1'b1;
        else               state_d  = S_GAP;
      end
      S_GAP: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(LOAD_GAP - 1)) gap_done = 1'b1;
      end
      S_STREAM: begin
        in_rdy_c = 1'b1;
        if (in_vld) begin
          char_in_d     = in_data;
          char_in_vld_d = 1'b1;
          if (in_eop) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(EOP_DELAY - 1)) begin
          eop_d     = 1'b1;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The held sop byte goes out first; a single-byte packet drains straight away.
    if (gap_done) begin
      char_in_d     = hold_data_q;
      char_in_vld_d = 1'b1;
      cnt_d         = '0;
      state_d       = hold_eop_q ? S_DRAIN : S_STREAM;
    end
  end

  always_ff @(posedge clk) begin
    key_tab_q <= key_tab_d;
    if (rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      key_q           <= '0;
      hold_data_q     <= '0;
      hold_eop_q      <= 1'b0;
      vld_tab_q       <= '0;
      en_tab_q        <= {NUM_STREAMS{DEFAULT_EN}};
      alloc_ptr_q     <= '0;
      char_in_q       <= '0;
      char_in_vld_q   <= 1'b0;
      load_state_q    <= 1'b0;
      new_stream_id_q <= 1'b0;
      stream_id_q     <= '0;
      enable_q        <= 1'b0;
      eop_q           <= 1'b0;
      pkt_cnt_q       <= '0;
      evict_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      key_q           <= key_d;
      hold_data_q     <= hold_data_d;
      hold_eop_q      <= hold_eop_d;
      vld_tab_q       <= vld_tab_d;
      en_tab_q        <= en_tab_d;
      alloc_ptr_q     <= alloc_ptr_d;
      char_in_q       <= char_in_d;
      char_in_vld_q   <= char_in_vld_d;
      load_state_q    <= load_state_d;
      new_stream_id_q <= new_stream_id_d;
      stream_id_q     <= stream_id_d;
      enable_q        <= enable_d;
      eop_q           <= eop_d;
      pkt_cnt_q       <= pkt_cnt_d;
      evict_cnt_q     <= evict_cnt_d;
    end
  end

  assign in_rdy        = in_rdy_c && !rst;
  assign char_in       = char_in_q;
  assign char_in_vld   = char_in_vld_q;
  assign load_state    = load_state_q;
  assign new_stream_id = new_stream_id_q;
  assign stream_id     = stream_id_q;
  assign enable        = enable_q;
  assign eop           = eop_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign evict_cnt     = evict_cnt_q;

endmodule
